// File: rtl/obstacle_spawner.sv
// obstacle_spawner: steps up to four obstacle lanes once per accepted game tick.
// Each accepted tick snapshots the random word and runs one scan, one lane per
// cycle. A lane that moves shifts by one cell and may insert an obstacle at its
// entry cell, subject to a minimum gap and a density threshold.
// Optional feature: define OBST_SPAWN_LFSR_EN to whiten the captured random
// word with an internal 14-bit LFSR.
module obstacle_spawner #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 16,
    parameter int GAP_MIN   = 2,
    parameter int DENSITY   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [13:0]                 rnd,
    input  logic                        tick,
    input  logic                        run,
    output logic [NUM_LANES*LANE_W-1:0] lane_map,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        spawn_valid,
    output logic [1:0]                  spawn_lane,
    output logic [7:0]                  spawn_cnt,
    output logic [3:0]                  drop_cnt
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                             state, state_nxt;
    logic [1:0]                         idx, idx_nxt;
    logic [13:0]                        rnd_q, rnd_cap;
    logic                               accept;
    logic [NUM_LANES-1:0]               lane_sp;
    logic [NUM_LANES-1:0][LANE_W-1:0]   lanes;

    // A tick is taken whenever no scan is running (IDLE or the DONE cycle).
    assign accept   = tick && run && (state != SCAN);
    assign lane_map = lanes;

`ifdef OBST_SPAWN_LFSR_EN
    logic [13:0] lfsr;

    // Fibonacci LFSR (taps 14,13,12,2); steps after the capture on each accepted tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         lfsr <= 14'h0001;
        else if (accept) lfsr <= {lfsr[12:0], lfsr[13] ^ lfsr[12] ^ lfsr[11] ^ lfsr[1]};
    end

    assign rnd_cap = rnd ^ lfsr;
`else
    assign rnd_cap = rnd;
`endif

    // State, lane index and random snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
            rnd_q <= 14'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) rnd_q <= rnd_cap;
        end
    end

    // Next-state logic and per-cycle status outputs.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        busy        = 1'b0;
        frame_done  = 1'b0;
        spawn_valid = 1'b0;
        spawn_lane  = 2'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SCAN;
                    idx_nxt   = 2'd0;
                end
            end
            SCAN: begin
                busy        = 1'b1;
                spawn_valid = |lane_sp;
                spawn_lane  = (|lane_sp) ? idx : 2'd0;
                if (idx == 2'(NUM_LANES - 1)) state_nxt = DONE;
                else                          idx_nxt   = idx + 2'd1;
            end
            DONE: begin
                frame_done = 1'b1;
                if (accept) begin
                    state_nxt = SCAN;
                    idx_nxt   = 2'd0;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Spawn counter wraps; drop counter saturates and counts ticks seen mid-scan.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spawn_cnt <= 8'd0;
            drop_cnt  <= 4'd0;
        end else begin
            if (|lane_sp) spawn_cnt <= spawn_cnt + 8'd1;
            if (state == SCAN && tick && drop_cnt != 4'hF) drop_cnt <= drop_cnt + 4'd1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic              act, mv, sp;
        logic [2:0]        gap, slice;
        logic [LANE_W-1:0] map, nxt;

        assign act   = (state == SCAN) && (idx == 2'(i));
        assign slice = rnd_q[3*i +: 3];
        assign sp    = mv && (gap >= 3'(GAP_MIN)) && ({1'b0, slice} < 4'(DENSITY));

        if (i % 2 == 1) begin : g_odd
            logic ph;

            // Odd lanes move every other scan; phase flips on every visit.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)      ph <= 1'b0;
                else if (act) ph <= ~ph;
            end

            assign mv  = act && ph;
            assign nxt = {sp, map[LANE_W-1:1]};
        end else begin : g_even
            assign mv  = act;
            assign nxt = {map[LANE_W-2:0], sp};
        end

        // Occupancy shift and gap tracking; untouched when the lane stays put.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                map <= '0;
                gap <= 3'(GAP_MIN);
            end else if (mv) begin
                map <= nxt;
                if (sp)               gap <= 3'd0;
                else if (gap != 3'd7) gap <= gap + 3'd1;
            end
        end

        assign lanes[i]   = map;
        assign lane_sp[i] = sp;
    end

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner: directed sequence with a lane model and a spawn scoreboard.
module tb_obstacle_spawner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] rnd = 14'd0;
    logic        tick = 1'b0;
    logic        run = 1'b0;
    logic [63:0] lane_map;
    logic        busy, frame_done, spawn_valid;
    logic [1:0]  spawn_lane;
    logic [7:0]  spawn_cnt;
    logic [3:0]  drop_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [3:0][15:0] m_map;
    logic [2:0]       m_gap [4];
    logic             m_ph  [4];
    logic [7:0]       m_cnt;
    int               exp_q [$];

    obstacle_spawner dut (
        .clk(clk), .rst(rst), .rnd(rnd), .tick(tick), .run(run),
        .lane_map(lane_map), .busy(busy), .frame_done(frame_done),
        .spawn_valid(spawn_valid), .spawn_lane(spawn_lane),
        .spawn_cnt(spawn_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_map = '0;
        m_cnt = 8'd0;
        for (int i = 0; i < 4; i++) begin
            m_gap[i] = 3'd2;
            m_ph[i]  = 1'b0;
        end
        exp_q.delete();
    endtask

    // One accepted tick of the lane model; returns the per-lane spawn mask.
    task automatic model_tick(input logic [13:0] r, output logic [3:0] mask);
        logic       mv, sp;
        logic [2:0] s;
        mask = 4'd0;
        for (int i = 0; i < 4; i++) begin
            s  = r[3*i +: 3];
            mv = (i % 2 == 0) || m_ph[i];
            if (i % 2 == 1) m_ph[i] = ~m_ph[i];
            if (mv) begin
                sp = (m_gap[i] >= 3'd2) && (s < 3'd3);
                if (i % 2 == 0) m_map[i] = {m_map[i][14:0], sp};
                else            m_map[i] = {sp, m_map[i][15:1]};
                if (sp) begin
                    m_gap[i] = 3'd0;
                    m_cnt    = m_cnt + 8'd1;
                    mask[i]  = 1'b1;
                    exp_q.push_back(i);
                end else if (m_gap[i] != 3'd7) begin
                    m_gap[i] = m_gap[i] + 3'd1;
                end
            end
        end
    endtask

    // Scoreboard: every spawn pulse must match the next expected lane.
    always @(negedge clk) begin
        if (!rst && spawn_valid) begin
            if (exp_q.size() == 0) check("spawn_unexpected", 64'(spawn_valid), 64'd0);
            else                   check("spawn_lane", 64'(spawn_lane), 64'(exp_q.pop_front()));
        end
    end

    // Full accepted tick with per-cycle busy/spawn timing and final state checks.
    task automatic do_tick(input logic [13:0] r);
        logic [3:0] m;
        @(negedge clk);
        rnd  = r;
        tick = 1'b1;
        model_tick(r, m);
        @(negedge clk);
        tick = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("busy_scan", 64'(busy), 64'd1);
            check("spawn_timing", 64'(spawn_valid), 64'(m[k]));
            @(negedge clk);
        end
        check("frame_done", 64'(frame_done), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("frame_done_pulse", 64'(frame_done), 64'd0);
        check("lane_map", lane_map, 64'(m_map));
        check("spawn_cnt", 64'(spawn_cnt), 64'(m_cnt));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0]  mk;
        logic [63:0] map_snap;
        model_reset();

        // reset state
        do_reset();
        check("rst_lane_map", lane_map, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_spawn_valid", 64'(spawn_valid), 64'd0);
        check("rst_spawn_lane", 64'(spawn_lane), 64'd0);
        check("rst_spawn_cnt", 64'(spawn_cnt), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);

        // first tick with rnd=0: lanes 0 and 2 spawn
        run = 1'b1;
        do_tick(14'd0);
        check("t1_map", lane_map, 64'h0000_0001_0000_0001);
        check("t1_cnt", 64'(spawn_cnt), 64'd2);

        // ticks 2..4
        do_tick(14'd0);
        check("t2_lane0", 64'(lane_map[15:0]), 64'h0002);
        check("t2_lane1", 64'(lane_map[31:16]), 64'h8000);
        do_tick(14'd0);
        check("t3_lane0", 64'(lane_map[15:0]), 64'h0004);
        do_tick(14'd0);
        check("t4_lane0", 64'(lane_map[15:0]), 64'h0009);
        check("t4_lane1", 64'(lane_map[31:16]), 64'h4000);
        check("t4_cnt", 64'(spawn_cnt), 64'd6);

        // all slices 7: never spawn
        do_reset();
        for (int n = 0; n < 20; n++) do_tick(14'h3FFF);
        check("nospawn_map", lane_map, 64'd0);
        check("nospawn_cnt", 64'(spawn_cnt), 64'd0);

        // tick held high for six cycles: one scan plus a restart in DONE
        @(negedge clk);
        rnd  = 14'h0A5C;
        tick = 1'b1;
        model_tick(14'h0A5C, mk);
        model_tick(14'h0A5C, mk);
        repeat (6) @(posedge clk);
        #1 tick = 1'b0;
        check("held_second_scan", 64'(busy), 64'd1);
        repeat (6) @(negedge clk);
        check("held_drop_cnt", 64'(drop_cnt), 64'd4);
        check("held_busy_idle", 64'(busy), 64'd0);
        check("held_map", lane_map, 64'(m_map));
        check("held_cnt", 64'(spawn_cnt), 64'(m_cnt));

        // run=0: ticks ignored entirely
        run = 1'b0;
        map_snap = lane_map;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            rnd  = 14'd0;
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            check("norun_busy", 64'(busy), 64'd0);
        end
        check("norun_map", lane_map, map_snap);
        check("norun_cnt", 64'(spawn_cnt), 64'(m_cnt));
        check("norun_drop", 64'(drop_cnt), 64'd4);
        run = 1'b1;
        do_tick(14'd0);

        // random patterns against the model
        for (int n = 0; n < 10; n++) do_tick(14'($urandom));
        check("rand_drop", 64'(drop_cnt), 64'd4);

        // reset in the middle of a scan
        @(negedge clk);
        rnd  = 14'd0;
        tick = 1'b1;
        model_tick(14'd0, mk);
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("abort_map", lane_map, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_spawn_valid", 64'(spawn_valid), 64'd0);
        check("abort_cnt", 64'(spawn_cnt), 64'd0);
        check("abort_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        check("abort_frame_done", 64'(frame_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_tick(14'd0);
        check("post_abort_map", lane_map, 64'h0000_0001_0000_0001);
        check("post_abort_cnt", 64'(spawn_cnt), 64'd2);

        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop so the run always ends even if the DUT wedges.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
